// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard: in-flight writer slot layout,
// standard result-ready stages and the forwarding-select width helper.
package pipe_hazard_pkg;

  // Slot field widths; the top-level RF_ADDRESS / LAT_W parameters must match these.
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned LAT_BITS = 3;

  localparam logic [LAT_BITS-1:0] LAT_ALU  = LAT_BITS'(1);
  localparam logic [LAT_BITS-1:0] LAT_LOAD = LAT_BITS'(2);

  typedef struct packed {
    logic                valid;
    logic [RF_AW-1:0]    rd;
    logic                regwrite;
    logic [LAT_BITS-1:0] lat;
    logic [RF_AW-1:0]    rs1;
    logic [RF_AW-1:0]    rs2;
    logic                use_rs1;
    logic                use_rs2;
  } slot_t;

  function automatic int unsigned sel_w(input int unsigned nstages);
    return (nstages > 1) ? $clog2(nstages) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_youngest_match.sv
// Priority encoder: finds the youngest (lowest-index) writer slot at or after START whose rd
// matches rs, and reports whether that slot's result is available LOOKAHEAD cycles from now.
module youngest_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGES   = 3,
  parameter int unsigned START     = 0,
  parameter int unsigned LOOKAHEAD = 1,
  localparam int unsigned SEL_W    = sel_w(NSTAGES)
) (
  input  logic [RF_AW-1:0]   rs_i,
  input  logic               use_i,
  input  slot_t [NSTAGES-1:0] slots_i,
  output logic               hit_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               ready_o
);

  // Only rd/valid/regwrite/lat are inspected here.
  logic unused_slot_bits;
  assign unused_slot_bits = ^slots_i;

  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    ready_o = 1'b0;
    // x0 never hazards; rd == rs != 0 implies the slot writes a real register.
    if (use_i && (rs_i != '0)) begin
      // Walk oldest to youngest so the lowest matching index wins.
      for (int k = int'(NSTAGES) - 1; k >= int'(START); k--) begin
        if (slots_i[k].valid && slots_i[k].regwrite && (slots_i[k].rd == rs_i)) begin
          hit_o   = 1'b1;
          idx_o   = SEL_W'(k);
          ready_o = (int'(slots_i[k].lat) <= (k + int'(LOOKAHEAD)));
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard-detection and forwarding controller beside decode: tracks NSTAGES in-flight writers,
// stalls ID on unforwardable operands and selects EX forwarding sources.
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NSTAGES    = 3,
  parameter int unsigned RF_ADDRESS = RF_AW,
  parameter int unsigned LAT_W      = LAT_BITS,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SEL_W     = sel_w(NSTAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic [LAT_W-1:0]      id_lat,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic                  fwd_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  slot_t [NSTAGES-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic               id_a_hit, id_a_rdy, id_b_hit, id_b_rdy;
  logic               ex_a_hit, ex_a_rdy, ex_b_hit, ex_b_rdy;
  logic [SEL_W-1:0]   ex_a_idx, ex_b_idx;
  logic [2*SEL_W-1:0] unused_id_idx;
  slot_t              id_slot;

  // ID looks one cycle ahead: it will sit in EX when slot k has moved to k+1.
  youngest_match #(.NSTAGES(NSTAGES), .START(0), .LOOKAHEAD(1)) u_id_rs1 (
    .rs_i    (id_rs1),
    .use_i   (id_use_rs1),
    .slots_i (slots_q),
    .hit_o   (id_a_hit),
    .idx_o   (unused_id_idx[SEL_W-1:0]),
    .ready_o (id_a_rdy)
  );

  youngest_match #(.NSTAGES(NSTAGES), .START(0), .LOOKAHEAD(1)) u_id_rs2 (
    .rs_i    (id_rs2),
    .use_i   (id_use_rs2),
    .slots_i (slots_q),
    .hit_o   (id_b_hit),
    .idx_o   (unused_id_idx[2*SEL_W-1:SEL_W]),
    .ready_o (id_b_rdy)
  );

  youngest_match #(.NSTAGES(NSTAGES), .START(1), .LOOKAHEAD(0)) u_ex_rs1 (
    .rs_i    (slots_q[0].rs1),
    .use_i   (slots_q[0].use_rs1 & slots_q[0].valid),
    .slots_i (slots_q),
    .hit_o   (ex_a_hit),
    .idx_o   (ex_a_idx),
    .ready_o (ex_a_rdy)
  );

  youngest_match #(.NSTAGES(NSTAGES), .START(1), .LOOKAHEAD(0)) u_ex_rs2 (
    .rs_i    (slots_q[0].rs2),
    .use_i   (slots_q[0].use_rs2 & slots_q[0].valid),
    .slots_i (slots_q),
    .hit_o   (ex_b_hit),
    .idx_o   (ex_b_idx),
    .ready_o (ex_b_rdy)
  );

  always_comb begin
    stall     = id_valid & ~flush & ((id_a_hit & ~id_a_rdy) | (id_b_hit & ~id_b_rdy));
    fwd_a_sel = (slots_q[0].valid && ex_a_hit) ? ex_a_idx : '0;
    fwd_b_sel = (slots_q[0].valid && ex_b_hit) ? ex_b_idx : '0;
    fwd_err   = slots_q[0].valid & ((ex_a_hit & ~ex_a_rdy) | (ex_b_hit & ~ex_b_rdy));
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid & ~stall & ~flush;
    id_slot.rd       = id_rd;
    id_slot.regwrite = id_regwrite;
    // A zero ready-stage is meaningless; treat it like an ALU result.
    id_slot.lat      = (id_lat == '0) ? LAT_W'(1) : id_lat;
    id_slot.rs1      = id_rs1;
    id_slot.rs2      = id_rs2;
    id_slot.use_rs1  = id_use_rs1;
    id_slot.use_rs2  = id_use_rs2;

    slots_d     = slots_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      for (int k = int'(NSTAGES) - 1; k > 0; k--) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = id_slot.valid ? id_slot : '0;
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: table-driven cycle vectors on a 3-stage instance, plus
// reset, saturation and long-latency sequences on a 5-stage instance with narrow counters.
module tb_pipe_hazard_scoreboard;

  typedef struct packed {
    logic       hold;
    logic       flush;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [2:0] lat;
    logic       e_stall;
    logic [1:0] e_sa;
    logic [1:0] e_sb;
    logic       chk5;
    logic       e5_stall;
    logic [2:0] e5_sa;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, hold, flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite;
  logic [2:0] id_lat;

  logic        stall3, err3;
  logic [1:0]  sa3, sb3;
  logic [31:0] scnt3, fcnt3;
  logic        stall5, err5;
  logic [2:0]  sa5, sb5;
  logic [1:0]  scnt5, fcnt5;

  int   total = 0;
  int   bad = 0;
  int   m_scnt = 0;
  int   m_fcnt = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_scoreboard u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_lat      (id_lat),
    .stall       (stall3),
    .fwd_a_sel   (sa3),
    .fwd_b_sel   (sb3),
    .fwd_err     (err3),
    .stall_cnt   (scnt3),
    .flush_cnt   (fcnt3)
  );

  pipe_hazard_scoreboard #(.NSTAGES(5), .CNT_W(2)) u_dut5 (
    .clk         (clk),
    .reset       (reset),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_lat      (id_lat),
    .stall       (stall5),
    .fwd_a_sel   (sa5),
    .fwd_b_sel   (sb5),
    .fwd_err     (err5),
    .stall_cnt   (scnt5),
    .flush_cnt   (fcnt5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t ins(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit rw, input int lat, input bit st,
                               input int sa, input int sb);
    vec_t v;
    v         = '0;
    v.v       = 1'b1;
    v.rs1     = 5'(rs1);
    v.rs2     = 5'(rs2);
    v.u1      = u1;
    v.u2      = u2;
    v.rd      = 5'(rd);
    v.rw      = rw;
    v.lat     = 3'(lat);
    v.e_stall = st;
    v.e_sa    = 2'(sa);
    v.e_sb    = 2'(sb);
    return v;
  endfunction

  function automatic vec_t nop(input int sa, input int sb);
    vec_t v;
    v      = '0;
    v.e_sa = 2'(sa);
    v.e_sb = 2'(sb);
    return v;
  endfunction

  function automatic vec_t with5(input vec_t vin, input bit st, input int sa);
    vec_t v;
    v          = vin;
    v.chk5     = 1'b1;
    v.e5_stall = st;
    v.e5_sa    = 3'(sa);
    return v;
  endfunction

  // One pipeline cycle: drive just after the edge, compare combinational outputs mid-cycle.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    hold        = v.hold;
    flush       = v.flush;
    id_valid    = v.v;
    id_rs1      = v.rs1;
    id_rs2      = v.rs2;
    id_use_rs1  = v.u1;
    id_use_rs2  = v.u2;
    id_rd       = v.rd;
    id_regwrite = v.rw;
    id_lat      = v.lat;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("r%0d stall", idx), 32'(stall3), 32'(e.e_stall));
    check($sformatf("r%0d fwd_a", idx), 32'(sa3), 32'(e.e_sa));
    check($sformatf("r%0d fwd_b", idx), 32'(sb3), 32'(e.e_sb));
    check($sformatf("r%0d fwd_err", idx), 32'(err3), 32'd0);
    check($sformatf("r%0d stall_cnt", idx), scnt3, 32'(m_scnt));
    check($sformatf("r%0d flush_cnt", idx), fcnt3, 32'(m_fcnt));
    if (e.chk5) begin
      check($sformatf("r%0d n5 stall", idx), 32'(stall5), 32'(e.e5_stall));
      check($sformatf("r%0d n5 fwd_a", idx), 32'(sa5), 32'(e.e5_sa));
      check($sformatf("r%0d n5 fwd_b", idx), 32'(sb5), 32'd0);
      check($sformatf("r%0d n5 fwd_err", idx), 32'(err5), 32'd0);
    end
    if (!e.hold) begin
      if (e.e_stall) m_scnt++;
      if (e.flush) m_fcnt++;
    end
  endtask

  initial begin
    vec_t v;
    int   row;
    reset = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = '0; id_regwrite = 1'b0; id_lat = '0;

    // Load-use: lw x5; add x6,x5,x1
    tbl.push_back(ins(2, 0, 1, 0, 5, 1, 2, 0, 0, 0));
    tbl.push_back(ins(5, 1, 1, 1, 6, 1, 1, 1, 0, 0));
    tbl.push_back(ins(5, 1, 1, 1, 6, 1, 1, 0, 0, 0));
    tbl.push_back(nop(2, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    // ALU chain: add x5; sub x7,x5,x5
    tbl.push_back(ins(1, 2, 1, 1, 5, 1, 1, 0, 0, 0));
    tbl.push_back(ins(5, 5, 1, 1, 7, 1, 1, 0, 0, 0));
    tbl.push_back(nop(1, 1));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    // Youngest wins: add x5; lw x5; add x8,x5
    tbl.push_back(ins(1, 0, 1, 0, 5, 1, 1, 0, 0, 0));
    tbl.push_back(ins(2, 0, 1, 0, 5, 1, 2, 0, 0, 0));
    tbl.push_back(ins(5, 0, 1, 0, 8, 1, 1, 1, 0, 0));
    tbl.push_back(ins(5, 0, 1, 0, 8, 1, 1, 0, 0, 0));
    tbl.push_back(nop(2, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    // x0 writer/readers, then an unused rs2 that matches a pending load
    tbl.push_back(ins(1, 2, 1, 1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(ins(0, 0, 1, 1, 9, 1, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(ins(2, 0, 1, 0, 5, 1, 2, 0, 0, 0));
    tbl.push_back(ins(3, 5, 1, 0, 10, 1, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    // Flush beats a load-use stall; the flushed add must not reach EX
    tbl.push_back(ins(2, 0, 1, 0, 5, 1, 2, 0, 0, 0));
    v = ins(5, 1, 1, 1, 6, 1, 1, 0, 0, 0);
    v.flush = 1'b1;
    tbl.push_back(v);
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));
    // Hold for 3 cycles mid-stall: stall persists, slots and counters frozen
    tbl.push_back(ins(2, 0, 1, 0, 5, 1, 2, 0, 0, 0));
    v = ins(5, 0, 1, 0, 6, 1, 1, 1, 0, 0);
    v.hold = 1'b1;
    tbl.push_back(v);
    tbl.push_back(v);
    tbl.push_back(v);
    v.hold = 1'b0;
    tbl.push_back(v);
    tbl.push_back(ins(5, 0, 1, 0, 6, 1, 1, 0, 0, 0));
    tbl.push_back(nop(2, 0));
    tbl.push_back(nop(0, 0));
    tbl.push_back(nop(0, 0));

    #12;
    check("reset stall", 32'(stall3), 32'd0);
    check("reset fwd_a", 32'(sa3), 32'd0);
    check("reset fwd_b", 32'(sb3), 32'd0);
    check("reset fwd_err", 32'(err3), 32'd0);
    check("reset stall_cnt", scnt3, 32'd0);
    check("reset flush_cnt", fcnt3, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    row = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], row);
      row++;
    end

    // Reset mid-stream: stalled ID and an active forward, then async clear before the edge
    run_vec(ins(1, 0, 1, 0, 5, 1, 1, 0, 0, 0), row++);
    run_vec(ins(5, 0, 1, 0, 9, 1, 2, 0, 0, 0), row++);
    run_vec(ins(9, 0, 1, 0, 10, 1, 1, 1, 1, 0), row++);
    reset = 1'b0;
    #1;
    check("async stall", 32'(stall3), 32'd0);
    check("async fwd_a", 32'(sa3), 32'd0);
    check("async fwd_b", 32'(sb3), 32'd0);
    check("async fwd_err", 32'(err3), 32'd0);
    check("async stall_cnt", scnt3, 32'd0);
    check("async flush_cnt", fcnt3, 32'd0);
    check("async n5 stall", 32'(stall5), 32'd0);
    check("async n5 stall_cnt", 32'(scnt5), 32'd0);
    check("async n5 flush_cnt", 32'(fcnt5), 32'd0);
    m_scnt = 0;
    m_fcnt = 0;
    id_valid = 1'b0;
    #1;
    reset = 1'b1;

    // Writer with ready stage 4: 5-stage instance stalls 3 cycles then forwards from slot 4;
    // the 3-stage instance also stalls 3 cycles but the writer retires before EX.
    for (int rnd = 0; rnd < 2; rnd++) begin
      run_vec(with5(ins(1, 0, 1, 0, 5, 1, 4, 0, 0, 0), 0, 0), row++);
      for (int s = 0; s < 3; s++) begin
        run_vec(with5(ins(5, 0, 1, 0, 6, 1, 1, 1, 0, 0), 1, 0), row++);
      end
      run_vec(with5(ins(5, 0, 1, 0, 6, 1, 1, 0, 0, 0), 0, 0), row++);
      run_vec(with5(nop(0, 0), 0, 4), row++);
      // 2-bit counter reaches all-ones after the first round and must stay there
      check($sformatf("n5 stall_cnt round%0d", rnd), 32'(scnt5), 32'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order RISC-V pipeline. Replaces the fixed EX/MEM/WB compare pair and the load-use-only stall check.
- Holds a shift register of NSTAGES in-flight writer slots. Slot 0 is EX, slot NSTAGES-1 is WB.
- Each writer carries its own result-ready stage, so multi-cycle units (loads, future MUL/DIV) stall correctly.
- Sits beside the decode stage. It drives the IF/ID stall, the ID/EX bubble and the EX operand forwarding muxes, and exposes stall/flush counters.

Parameters:
- NSTAGES, 3, writer slots after ID (EX, MEM, WB); legal range 2..8.
- RF_ADDRESS, 5, register index width.
- LAT_W, 3, width of the per-instruction ready-stage field.
- CNT_W, 32, performance counter width.
- Derived: SEL_W = $clog2(NSTAGES), forwarding-select width.

Ports:
- clk  in  1  pipeline clock; all state on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- hold  in  1  global freeze (memory wait); no slot moves.
- flush  in  1  taken branch from EX; kills the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  RF_ADDRESS  ID source registers.
- id_use_rs1, id_use_rs2  in  1  source is actually read.
- id_rd  in  RF_ADDRESS  ID destination register.
- id_regwrite  in  1  ID writes rd.
- id_lat  in  LAT_W  first slot index whose pipeline register holds the result (ALU=1, load=2).
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX.
- fwd_a_sel, fwd_b_sel  out  SEL_W  EX operand source: 0 = ID/EX register value; j = result held in slot j.
- fwd_err  out  1  EX needs a slot that is not yet ready (must never assert).
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Slot fields: valid, rd, regwrite, lat, rs1, rs2, use_rs1, use_rs2. A slot is a "writer" when valid & regwrite & rd != 0.
- Reset (reset=0, asynchronous): all slots invalid; stall=0, fwd_*_sel=0, fwd_err=0, counters=0.
- Advance, when hold=0 and reset is deasserted:
  - slot[k+1] <= slot[k] for every k; slot[NSTAGES-1] retires.
  - slot[0] <= ID fields if id_valid & !stall & !flush; otherwise a bubble (valid=0).
- Hold: all slots and counters keep their values. stall and fwd_* are still computed from the current state.
- ID hazard check (combinational):
  - For each used rs != x0, find the youngest matching writer slot k (lowest k).
  - Hazard if slot[k].lat > k+1, i.e. the data is not forwardable when ID reaches EX next cycle.
  - stall = id_valid & !flush & (hazard on rs1 | hazard on rs2).
  - The youngest match decides; an older ready match never masks a younger unready one.
- EX forwarding (combinational, driven from slot[0]):
  - For each used rs != x0, search slots 1..NSTAGES-1 for the youngest matching writer j.
  - sel = j if found, else 0.
  - fwd_err = 1 if j < slot[j].lat.
  - If slot[0] is invalid, both sels are 0.
- Flush priority: flush beats stall. stall is forced to 0, slot[0] gets a bubble, and the branch already in slot[0] advances normally.
- Latency: stall and fwd_* are 0-cycle (combinational from state and inputs). Slot update is 1 cycle.
- Register file must be write-first; a WB writer retiring the same cycle ID reads is not forwarded here.
- Counters:
  - stall_cnt += 1 when stall & !hold; flush_cnt += 1 when flush & !hold.
  - Both saturate at all-ones; no wrap.
- id_lat = 0 is treated as 1. id_lat > NSTAGES-1 means the result is never forwardable, so ID stalls until the writer retires.

Decomposition:
- Shared package pipe_hazard_pkg: typedef struct packed slot_t (fields above); constants LAT_ALU=1, LAT_LOAD=2; SEL_W function.
- Sub-module youngest_match: combinational priority encoder. Inputs are one rs, a use flag, the slot array and a start index. Outputs are hit, index and ready.
- youngest_match is instantiated four times: ID rs1/rs2 with start 0, EX rs1/rs2 with start 1.

Test Plan:
- Load-use: lw x5 (lat 2) then add x6,x5,x1 (NSTAGES=3) -> stall=1 for exactly 1 cycle, then fwd_a_sel=2, stall_cnt=1.
- ALU chain: add x5; sub x7,x5,x5 -> no stall; fwd_a_sel=1 and fwd_b_sel=1 when sub is in EX.
- Youngest-wins: add x5 then lw x5 then add x8,x5 -> stall 1 cycle, then sel=2 (the lw slot), never the older add.
- x0 and unused sources: add x0,... then add x9,x0,x0 -> stall=0, sel=0. id_use_rs2=0 with a matching rs2 -> no stall.
- Flush during hazard: lw x5; add x6,x5 with flush=1 in the same cycle -> stall=0, slot[0] bubble, flush_cnt=1, stall_cnt=0.
- Hold and reset: hold=1 for 3 cycles mid-stall -> slots frozen, counters unchanged. reset low mid-stream -> all outputs 0 immediately, before the next clock edge. NSTAGES=5 with id_lat=4 -> ID stalls 3 cycles.
